// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bundle between two requesters and the shared ALU
//
// Purpose: groups both requesters' operation handshakes and their response
//          handshakes into one bundle.
// Ports (signal groups):
//   req{0,1}_valid/ready      operation handshake, one per requester
//   req{0,1}_a/_b/_cin/_op    operands, carry/borrow in, opcode
//   rsp{0,1}_valid/ready      response handshake, one per requester
//   rsp_result/carry/err      response payload, shared by both requesters
// Modports: master = requester side, slave = arbiter side.
interface alu_arbiter_if;
   logic       req0_valid;
   logic       req0_ready;
   logic [3:0] req0_a;
   logic [3:0] req0_b;
   logic       req0_cin;
   logic [2:0] req0_op;
   logic       req1_valid;
   logic       req1_ready;
   logic [3:0] req1_a;
   logic [3:0] req1_b;
   logic       req1_cin;
   logic [2:0] req1_op;
   logic       rsp0_valid;
   logic       rsp0_ready;
   logic       rsp1_valid;
   logic       rsp1_ready;
   logic [3:0] rsp_result;
   logic       rsp_carry;
   logic       rsp_err;

   modport master (
      output req0_valid, req0_a, req0_b, req0_cin, req0_op,
      output req1_valid, req1_a, req1_b, req1_cin, req1_op,
      output rsp0_ready, rsp1_ready,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
      input  rsp_result, rsp_carry, rsp_err
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_cin, req0_op,
      input  req1_valid, req1_a, req1_b, req1_cin, req1_op,
      input  rsp0_ready, rsp1_ready,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
      output rsp_result, rsp_carry, rsp_err
   );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of one shared 4-bit ALU
//
// Purpose: accepts one operation at a time from either requester, executes it
//          on a single 4-bit ALU (add, subtract, AND, OR) and returns the
//          registered result to the requester that issued it.
// Parameters:
//   RR_EN   1 = round-robin between requesters on a tie, 0 = requester 0 wins
// Ports:
//   clk     clock, rising edge
//   rst_n   asynchronous active-low reset
//   bus     alu_arbiter_if.slave (request/response handshakes and payload)
module alu_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t     state;
   logic       owner;        // requester that owns the transaction in flight
   logic       last_served;  // requester accepted most recently
   logic [3:0] op_a;
   logic [3:0] op_b;
   logic       op_cin;
   logic [2:0] op_code;

   logic       grant;
   logic       accept;
   logic [4:0] alu_sum;
   logic [4:0] alu_diff;
   logic [3:0] alu_result;
   logic       alu_carry;
   logic       alu_err;

   // Requester to serve this cycle; only meaningful in IDLE when a valid is up.
   always_comb begin
      grant = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         grant = RR_EN ? ~last_served : 1'b0;
      end else if (bus.req1_valid) begin
         grant = 1'b1;
      end
   end

   // rst_n gating keeps ready low while reset is held, even with valid up.
   assign bus.req0_ready = rst_n && (state == IDLE) && bus.req0_valid && !grant;
   assign bus.req1_ready = rst_n && (state == IDLE) && bus.req1_valid &&  grant;
   assign accept         = bus.req0_ready || bus.req1_ready;

   // Single shared datapath working on the latched operands only. The 5-bit
   // difference wraps negative, so bit 4 is exactly the borrow out.
   always_comb begin
      alu_sum    = {1'b0, op_a} + {1'b0, op_b} + {4'b0000, op_cin};
      alu_diff   = {1'b0, op_a} - {1'b0, op_b} - {4'b0000, op_cin};
      alu_result = 4'h0;
      alu_carry  = 1'b0;
      alu_err    = 1'b0;
      case (op_code)
         3'b000: begin
            alu_result = alu_sum[3:0];
            alu_carry  = alu_sum[4];
         end
         3'b001: begin
            alu_result = alu_diff[3:0];
            alu_carry  = alu_diff[4];
         end
         3'b010:  alu_result = op_a & op_b;
         3'b011:  alu_result = op_a | op_b;
         default: alu_err    = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         owner          <= 1'b0;
         last_served    <= 1'b1;
         op_a           <= 4'h0;
         op_b           <= 4'h0;
         op_cin         <= 1'b0;
         op_code        <= 3'b000;
         bus.rsp0_valid <= 1'b0;
         bus.rsp1_valid <= 1'b0;
         bus.rsp_result <= 4'h0;
         bus.rsp_carry  <= 1'b0;
         bus.rsp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  owner       <= grant;
                  last_served <= grant;
                  op_a        <= grant ? bus.req1_a   : bus.req0_a;
                  op_b        <= grant ? bus.req1_b   : bus.req0_b;
                  op_cin      <= grant ? bus.req1_cin : bus.req0_cin;
                  op_code     <= grant ? bus.req1_op  : bus.req0_op;
                  state       <= EXEC;
               end
            end
            EXEC: begin
               bus.rsp_result <= alu_result;
               bus.rsp_carry  <= alu_carry;
               bus.rsp_err    <= alu_err;
               bus.rsp0_valid <= ~owner;
               bus.rsp1_valid <=  owner;
               state          <= RESP;
            end
            RESP: begin
               // Only the owner's ready completes the response.
               if (owner ? bus.rsp1_ready : bus.rsp0_ready) begin
                  bus.rsp0_valid <= 1'b0;
                  bus.rsp1_valid <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
//
// Purpose: drives directed operations with hand-computed results into a
//          round-robin instance (bus_a) and a fixed-priority instance (bus_b).
// Ports: none (top-level bench).
module tb_alu_arbiter;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_fail;
   int   n_total;

   alu_arbiter_if bus_a ();
   alu_arbiter_if bus_b ();

   alu_arbiter #(.RR_EN(1'b1)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   alu_arbiter #(.RR_EN(1'b0)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_req(input bit id, input logic v, input logic [3:0] a,
                          input logic [3:0] b, input logic cin, input logic [2:0] op);
      if (!id) begin
         bus_a.req0_valid = v; bus_a.req0_a = a; bus_a.req0_b = b;
         bus_a.req0_cin = cin; bus_a.req0_op = op;
      end else begin
         bus_a.req1_valid = v; bus_a.req1_a = a; bus_a.req1_b = b;
         bus_a.req1_cin = cin; bus_a.req1_op = op;
      end
   endtask

   task automatic set_rsp_ready(input bit id, input logic v);
      if (!id) bus_a.rsp0_ready = v;
      else     bus_a.rsp1_ready = v;
   endtask

   // One transaction on bus_a; hold = cycles the response is stalled with the
   // non-owner's rsp_ready high and both requesters pushing new work.
   task automatic txn(input string tag, input bit id, input logic [3:0] a,
                      input logic [3:0] b, input logic cin, input logic [2:0] op,
                      input int hold, input logic [3:0] er, input logic ec,
                      input logic ee);
      logic own_v;
      logic oth_v;
      set_req(id, 1'b1, a, b, cin, op);
      bus_a.rsp0_ready = 1'b0;
      bus_a.rsp1_ready = 1'b0;
      #1;
      chk1({tag, "_grant"},   id ? bus_a.req1_ready : bus_a.req0_ready, 1'b1);
      chk1({tag, "_nogrant"}, id ? bus_a.req0_ready : bus_a.req1_ready, 1'b0);
      @(posedge clk); #1;
      set_req(id, 1'b0, ~a, ~b, ~cin, 3'b111);
      #1;
      chk1({tag, "_exec_rdy"}, bus_a.req0_ready | bus_a.req1_ready, 1'b0);
      chk1({tag, "_exec_rsp"}, bus_a.rsp0_valid | bus_a.rsp1_valid, 1'b0);
      @(posedge clk); #1;
      own_v = id ? bus_a.rsp1_valid : bus_a.rsp0_valid;
      oth_v = id ? bus_a.rsp0_valid : bus_a.rsp1_valid;
      chk1({tag, "_rsp_own"},   own_v, 1'b1);
      chk1({tag, "_rsp_other"}, oth_v, 1'b0);
      chk4({tag, "_result"}, bus_a.rsp_result, er);
      chk1({tag, "_carry"},  bus_a.rsp_carry, ec);
      chk1({tag, "_err"},    bus_a.rsp_err, ee);
      for (int i = 0; i < hold; i++) begin
         set_req(1'b0, 1'b1, 4'h1, 4'h2, 1'b0, 3'b000);
         set_req(1'b1, 1'b1, 4'h3, 4'h4, 1'b0, 3'b000);
         set_rsp_ready(~id, 1'b1);
         #1;
         chk1({tag, "_hold_rdy"}, bus_a.req0_ready | bus_a.req1_ready, 1'b0);
         @(posedge clk); #1;
         chk1({tag, "_hold_valid"}, id ? bus_a.rsp1_valid : bus_a.rsp0_valid, 1'b1);
         chk4({tag, "_hold_result"}, bus_a.rsp_result, er);
         chk1({tag, "_hold_carry"}, bus_a.rsp_carry, ec);
         chk1({tag, "_hold_err"}, bus_a.rsp_err, ee);
      end
      set_req(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 3'b000);
      set_req(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 3'b000);
      set_rsp_ready(~id, 1'b0);
      set_rsp_ready(id, 1'b1);
      @(posedge clk); #1;
      chk1({tag, "_done"}, bus_a.rsp0_valid | bus_a.rsp1_valid, 1'b0);
      set_rsp_ready(id, 1'b0);
   endtask

   initial begin
      n_pass  = 0;
      n_fail  = 0;
      n_total = 0;
      rst_n   = 1'b0;
      set_req(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 3'b000);
      set_req(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 3'b000);
      bus_a.rsp0_ready = 1'b0; bus_a.rsp1_ready = 1'b0;
      bus_b.req0_valid = 1'b0; bus_b.req0_a = 4'h0; bus_b.req0_b = 4'h0;
      bus_b.req0_cin = 1'b0;   bus_b.req0_op = 3'b000;
      bus_b.req1_valid = 1'b0; bus_b.req1_a = 4'h0; bus_b.req1_b = 4'h0;
      bus_b.req1_cin = 1'b0;   bus_b.req1_op = 3'b000;
      bus_b.rsp0_ready = 1'b0; bus_b.rsp1_ready = 1'b0;

      #12;
      chk1("rst_rsp0_valid", bus_a.rsp0_valid, 1'b0);
      chk1("rst_rsp1_valid", bus_a.rsp1_valid, 1'b0);
      chk4("rst_result", bus_a.rsp_result, 4'd0);
      chk1("rst_carry", bus_a.rsp_carry, 1'b0);
      chk1("rst_err", bus_a.rsp_err, 1'b0);
      chk1("rst_ready", bus_a.req0_ready | bus_a.req1_ready, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // add 9+8+1 = 18 -> result 2, carry 1 (accepted on first edge after release)
      txn("add", 1'b0, 4'd9, 4'd8, 1'b1, 3'b000, 0, 4'd2, 1'b1, 1'b0);
      // 3-5-0 = -2 -> 14 with borrow; 5-3-1 = 1 without borrow
      txn("sub_borrow", 1'b1, 4'd3, 4'd5, 1'b0, 3'b001, 0, 4'd14, 1'b1, 1'b0);
      txn("sub_plain",  1'b1, 4'd5, 4'd3, 1'b1, 3'b001, 0, 4'd1,  1'b0, 1'b0);
      // AND 12&10 = 8 with rsp1_ready pulsed during req0's response; OR = 14
      txn("and", 1'b0, 4'd12, 4'd10, 1'b0, 3'b010, 1, 4'd8,  1'b0, 1'b0);
      txn("or",  1'b0, 4'd12, 4'd10, 1'b1, 3'b011, 0, 4'd14, 1'b0, 1'b0);
      // illegal opcode, response stalled 5 cycles
      txn("illegal", 1'b0, 4'd4, 4'd4, 1'b1, 3'b110, 5, 4'd0, 1'b0, 1'b1);

      // reset during RESP: 7+1 = 8 from req0 (last served = 0 before reset)
      set_req(1'b0, 1'b1, 4'd7, 4'd1, 1'b0, 3'b000);
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 3'b000);
      @(posedge clk); #1;
      chk1("mid_rsp_valid", bus_a.rsp0_valid, 1'b1);
      chk4("mid_rsp_result", bus_a.rsp_result, 4'd8);
      rst_n = 1'b0;
      #1;
      chk1("mid_rst_valid", bus_a.rsp0_valid, 1'b0);
      chk4("mid_rst_result", bus_a.rsp_result, 4'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk1("post_rst_valid_a", bus_a.rsp0_valid | bus_a.rsp1_valid, 1'b0);
      @(posedge clk); #1;
      chk1("post_rst_valid_b", bus_a.rsp0_valid | bus_a.rsp1_valid, 1'b0);

      // round robin: both valid continuously -> 0,1,0,1
      set_req(1'b0, 1'b1, 4'd1, 4'd1, 1'b0, 3'b000);
      set_req(1'b1, 1'b1, 4'd2, 4'd2, 1'b0, 3'b000);
      bus_a.rsp0_ready = 1'b1;
      bus_a.rsp1_ready = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk1("rr_rdy0", bus_a.req0_ready, (k % 2) == 0);
         chk1("rr_rdy1", bus_a.req1_ready, (k % 2) == 1);
         @(posedge clk); #1;
         @(posedge clk); #1;
         chk1("rr_rsp0", bus_a.rsp0_valid, (k % 2) == 0);
         chk1("rr_rsp1", bus_a.rsp1_valid, (k % 2) == 1);
         chk4("rr_result", bus_a.rsp_result, ((k % 2) == 1) ? 4'd4 : 4'd2);
         @(posedge clk); #1;
      end
      set_req(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 3'b000);
      set_req(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 3'b000);

      // fixed priority: both valid continuously -> 0,0,0
      bus_b.req0_valid = 1'b1; bus_b.req0_a = 4'd6; bus_b.req0_b = 4'd3;
      bus_b.req0_op = 3'b011;
      bus_b.req1_valid = 1'b1; bus_b.req1_a = 4'd6; bus_b.req1_b = 4'd3;
      bus_b.req1_op = 3'b010;
      bus_b.rsp0_ready = 1'b1;
      bus_b.rsp1_ready = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk1("fp_rdy0", bus_b.req0_ready, 1'b1);
         chk1("fp_rdy1", bus_b.req1_ready, 1'b0);
         @(posedge clk); #1;
         @(posedge clk); #1;
         chk1("fp_rsp0", bus_b.rsp0_valid, 1'b1);
         chk1("fp_rsp1", bus_b.rsp1_valid, 1'b0);
         chk4("fp_result", bus_b.rsp_result, 4'd7);
         @(posedge clk); #1;
      end
      bus_b.req0_valid = 1'b0;
      bus_b.req1_valid = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, meaning 1 = round-robin grant between requesters, 0 = fixed priority with requester 0 always winning.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester i presents an operation.
REQ-005 req0_ready / req1_ready  output  1  operation accepted when valid and ready are both high on a rising edge.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  4  operands.
REQ-007 req0_cin / req1_cin  input  1  carry/borrow in.
REQ-008 req0_op / req1_op  input  3  opcode: 000 add, 001 subtract, 010 AND, 011 OR, 1xx illegal.
REQ-009 rsp0_valid / rsp1_valid  output  1  result available for requester i.
REQ-010 rsp0_ready / rsp1_ready  input  1  requester i consumes its result.
REQ-011 rsp_result  output  4  registered result, shared by both response ports.
REQ-012 rsp_carry  output  1  registered carry/borrow out.
REQ-013 rsp_err  output  1  high with the response when the opcode was illegal.

Function
REQ-014 The block SHALL contain exactly one 4-bit ALU datapath shared by both requesters.
REQ-015 Add SHALL produce {carry,result} = A + B + Cin (5-bit sum).
REQ-016 Subtract SHALL produce result = (A - B - Cin) mod 16, carry = 1 if A < B + Cin (borrow), else 0.
REQ-017 AND/OR SHALL produce bitwise A&B / A|B with carry = 0.
REQ-018 Illegal opcode SHALL produce result = 0, carry = 0, err = 1; err SHALL be 0 for legal opcodes.
REQ-019 FSM states: IDLE, EXEC, RESP.
REQ-020 IDLE: req_ready SHALL be high only for the granted requester among those with valid high (combinational grant); on acceptance SHALL latch a, b, cin, op and owner ID, go to EXEC.
REQ-021 IDLE with no valid request SHALL stay in IDLE with both req_ready low.
REQ-022 EXEC: SHALL compute on latched operands, register result/carry/err, go to RESP; lasts exactly one cycle.
REQ-023 RESP: rsp_valid SHALL be high for the owner only; response outputs SHALL hold stable until owner's rsp_ready is sampled high, then go to IDLE.
REQ-024 Latency: rsp_valid SHALL rise exactly 2 edges after the accept edge.
REQ-025 Both req_ready SHALL be low in EXEC and RESP; at most one request accepted per transaction.
REQ-026 RR_EN=1: when both valid in IDLE, grant SHALL go to the requester not served last; the last-served pointer SHALL update only on acceptance.
REQ-027 RR_EN=0: when both valid, requester 0 SHALL be granted.
REQ-028 A single valid requester SHALL be granted regardless of pointer.
REQ-029 rsp_ready of the non-owner SHALL be ignored; rsp_ready while not in RESP SHALL be ignored.
REQ-030 Requester input changes after acceptance SHALL not affect the transaction in flight.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, req_ready both 0, rsp_valid both 0, rsp_result = 0, rsp_carry = 0, rsp_err = 0, last-served pointer = requester 1 (so requester 0 wins the first tie).
REQ-032 Reset mid-transaction (EXEC or RESP) SHALL discard the transaction; no response is issued after release.
REQ-033 Release of rst_n SHALL take effect on the next rising edge; first acceptance possible on that edge.

Verification
REQ-034 req0 add A=9 B=8 Cin=1, rsp0_ready high -> rsp0_valid 2 edges after accept, result=2, carry=1, err=0.
REQ-035 req1 subtract A=3 B=5 Cin=0 -> result=14, carry=1; then A=5 B=3 Cin=1 -> result=1, carry=0.
REQ-036 RR_EN=1, both valid continuously, rsp_ready high -> grants alternate 0,1,0,1; RR_EN=0 -> grants 0,0,0.
REQ-037 req0 op=3'b110 -> result=0, carry=0, err=1; rsp0_ready held low 5 cycles -> outputs stable, req_ready both low, then single handshake returns to IDLE.
REQ-038 rst_n asserted during RESP -> all outputs 0 asynchronously; after release no stale rsp_valid, next tie granted to requester 0.
REQ-039 AND A=12 B=10 -> result=8; OR same -> result=14; carry=0 both; rsp1_ready pulsed during rsp0 response -> ignored.
